// File: rtl/ev22_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ev22_pkg
//  Description : Shared types and constants for the EV22 fetch/execute
//                sequencer: state encoding, opcode match patterns and the
//                instruction width.
//  Revision    : 1.0  initial release
// ============================================================================
package ev22_pkg;

    localparam int INSTR_W = 16;

    // Sequencer states; the encoding is visible on state_dbg.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXEC    = 3'd3,
        ST_MEMWAIT = 3'd4,
        ST_UPDATE  = 3'd5,
        ST_HALT    = 3'd6
    } state_t;

    // Opcode match patterns (upper opcode bits unless noted).
    localparam logic [4:0] OP_JMP = 5'b00100;  // 00100xxx
    localparam logic [4:0] OP_JZE = 5'b00101;  // 00101xxx
    localparam logic [4:0] OP_JNE = 5'b00110;  // 00110xxx
    localparam logic [4:0] OP_JCY = 5'b00111;  // 00111xxx
    localparam logic [5:0] OP_BSR = 6'b000111; // 000111ss
    localparam logic [7:0] OP_RET = 8'h41;     // full opcode

endpackage : ev22_pkg
`default_nettype wire

// File: rtl/pc_sequencer_ret_stack.sv
`default_nettype none
// ============================================================================
//  Module      : ret_stack
//  Description : LIFO return-address stack for BSR/RET.
//                push writes push_data at SP and increments SP; pop
//                decrements SP. top_data always shows the entry at SP-1.
//                The caller must not push when full nor pop when empty;
//                such requests are ignored here.
//  Ports       : clk, rst_n       - clock, async active-low reset
//                push, pop        - one-cycle requests (mutually exclusive)
//                push_data        - return address to store
//                top_data         - most recently pushed address
//                full, empty      - SP == DEPTH / SP == 0
//  Revision    : 1.0  initial release
// ============================================================================
module ret_stack #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] top_data,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    // SP is one bit wider than the index so that full and empty differ.
    logic [AW:0]       r_sp;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     w_wr_idx;
    logic [AW-1:0]     w_rd_idx;

    assign w_wr_idx = r_sp[AW-1:0];
    assign w_rd_idx = w_wr_idx - AW'(1);
    assign full     = (r_sp == (AW+1)'(DEPTH));
    assign empty    = (r_sp == '0);
    assign top_data = r_mem[w_rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp <= '0;
        end else if (push && !full) begin
            r_sp <= r_sp + 1'b1;
        end else if (pop && !empty) begin
            r_sp <= r_sp - 1'b1;
        end
    end

    // Storage needs no reset: an entry is only read after it was pushed.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            r_mem[w_wr_idx] <= push_data;
        end
    end

endmodule : ret_stack
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : EV22 fetch/execute sequencer. Owns the PC and the return
//                stack, fetches 16-bit instructions over a req/valid
//                handshake, issues one exec strobe per instruction and
//                resolves JMP/JZE/JNE/JCY/BSR/RET itself.
//  Build macro : SINGLE_STEP_EN - adds input 'step'; each rising edge of
//                step runs exactly one instruction, run is ignored.
//  Ports       : clk, rst_n            - clock, async active-low reset
//                run                   - level enable for free running
//                step                  - single-step (SINGLE_STEP_EN only)
//                imem_req/addr/valid/data - instruction fetch handshake
//                ir_opcode, ir_field   - latched instruction to decoder
//                exec_stb              - one pulse per instruction
//                mem_op, dp_done       - datapath memory access handshake
//                flag_z/n/cy           - datapath flags, sampled in UPDATE
//                fault                 - sticky stack over/underflow
//                state_dbg             - current state encoding
//  Revision    : 1.0  initial release
// ============================================================================
module pc_sequencer
    import ev22_pkg::*;
#(
    parameter int          PC_W        = 11,
    parameter int          STACK_DEPTH = 4,
    parameter int unsigned RESET_PC    = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
`ifdef SINGLE_STEP_EN
    input  logic               step,
`endif
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [7:0]         ir_opcode,
    output logic [7:0]         ir_field,
    output logic               exec_stb,
    input  logic               mem_op,
    input  logic               dp_done,
    input  logic               flag_z,
    input  logic               flag_n,
    input  logic               flag_cy,
    output logic               fault,
    output logic [2:0]         state_dbg
);

    state_t            r_state;
    state_t            w_next_state;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   w_next_pc;
    logic [7:0]        r_ir_opcode;
    logic [7:0]        r_ir_field;
    logic              r_fault;
    logic              w_set_fault;
    logic              w_push;
    logic              w_pop;
    logic              w_stack_full;
    logic              w_stack_empty;
    logic [PC_W-1:0]   w_stack_top;
    logic              w_start;
    state_t            w_after_update;

    // ------------------------------------------------------------------
    // Start / continue policy
    // ------------------------------------------------------------------
`ifdef SINGLE_STEP_EN
    logic r_step_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step_d <= 1'b0;
        end else begin
            r_step_d <= step;
        end
    end

    assign w_start        = step & ~r_step_d;
    assign w_after_update = ST_IDLE;
`else
    assign w_start        = run;
    assign w_after_update = run ? ST_FETCH : ST_IDLE;
`endif

    // ------------------------------------------------------------------
    // Instruction classification and PC candidates
    // ------------------------------------------------------------------
    logic            w_is_jmp, w_is_jze, w_is_jne, w_is_jcy, w_is_bsr, w_is_ret;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_jmp_target;
    logic [PC_W-1:0] w_bsr_target;

    assign w_is_jmp = (r_ir_opcode[7:3] == OP_JMP);
    assign w_is_jze = (r_ir_opcode[7:3] == OP_JZE);
    assign w_is_jne = (r_ir_opcode[7:3] == OP_JNE);
    assign w_is_jcy = (r_ir_opcode[7:3] == OP_JCY);
    assign w_is_bsr = (r_ir_opcode[7:2] == OP_BSR);
    assign w_is_ret = (r_ir_opcode == OP_RET);

    assign w_pc_inc     = r_pc + PC_W'(1);
    assign w_jmp_target = PC_W'({r_ir_opcode[2:0], r_ir_field});
    // The cast of a signed 10-bit value sign-extends the BSR displacement.
    assign w_bsr_target = w_pc_inc + PC_W'($signed({r_ir_opcode[1:0], r_ir_field}));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state, strobes and PC/stack decisions
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_set_fault  = 1'b0;
        imem_req     = 1'b0;
        exec_stb     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_start && !r_fault) begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    w_next_state = ST_DECODE;
                end
            end
            ST_DECODE: begin
                w_next_state = ST_EXEC;
            end
            ST_EXEC: begin
                exec_stb = 1'b1;
                // dp_done together with the strobe skips MEMWAIT entirely.
                if (mem_op && !dp_done) begin
                    w_next_state = ST_MEMWAIT;
                end else begin
                    w_next_state = ST_UPDATE;
                end
            end
            ST_MEMWAIT: begin
                if (dp_done) begin
                    w_next_state = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                w_next_pc    = w_pc_inc;
                w_next_state = w_after_update;
                if (w_is_jmp) begin
                    w_next_pc = w_jmp_target;
                end else if (w_is_jze) begin
                    if (flag_z) w_next_pc = w_jmp_target;
                end else if (w_is_jne) begin
                    if (!flag_n) w_next_pc = w_jmp_target;
                end else if (w_is_jcy) begin
                    if (flag_cy) w_next_pc = w_jmp_target;
                end else if (w_is_bsr) begin
                    if (w_stack_full) begin
                        w_set_fault  = 1'b1;
                        w_next_pc    = r_pc;
                        w_next_state = ST_HALT;
                    end else begin
                        w_push    = 1'b1;
                        w_next_pc = w_bsr_target;
                    end
                end else if (w_is_ret) begin
                    if (w_stack_empty) begin
                        w_set_fault  = 1'b1;
                        w_next_pc    = r_pc;
                        w_next_state = ST_HALT;
                    end else begin
                        w_pop     = 1'b1;
                        w_next_pc = w_stack_top;
                    end
                end
            end
            ST_HALT: begin
                w_next_state = ST_HALT;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // PC, instruction register and fault flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= PC_W'(RESET_PC);
            r_ir_opcode <= 8'h00;
            r_ir_field  <= 8'h00;
            r_fault     <= 1'b0;
        end else begin
            r_pc <= w_next_pc;
            if (r_state == ST_FETCH && imem_valid) begin
                r_ir_opcode <= imem_data[15:8];
                r_ir_field  <= imem_data[7:0];
            end
            if (w_set_fault) begin
                r_fault <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Return stack
    // ------------------------------------------------------------------
    ret_stack #(
        .DEPTH  (STACK_DEPTH),
        .DATA_W (PC_W)
    ) u_ret_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_pc_inc),
        .top_data  (w_stack_top),
        .full      (w_stack_full),
        .empty     (w_stack_empty)
    );

    assign imem_addr = r_pc;
    assign ir_opcode = r_ir_opcode;
    assign ir_field  = r_ir_field;
    assign fault     = r_fault;
    assign state_dbg = r_state;

endmodule : pc_sequencer
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Self-checking bench for pc_sequencer. An instruction
//                memory responder with programmable latency and a small
//                datapath model surround the DUT; expected fetch addresses
//                are queued before each program runs and compared as the
//                DUT fetches them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pc_sequencer;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_EXEC = 3'd3,
                           S_MEMWAIT = 3'd4, S_UPDATE = 3'd5, S_HALT = 3'd6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic        imem_req;
    logic [10:0] imem_addr;
    logic        resp_valid = 1'b0;
    logic        force_valid = 1'b0;
    logic        imem_valid;
    logic [15:0] imem_data = 16'h0000;
    logic [7:0]  ir_opcode, ir_field;
    logic        exec_stb;
    logic        mem_op = 1'b0;
    logic        dp_done = 1'b0;
    logic        flag_z = 1'b0, flag_n = 1'b0, flag_cy = 1'b0;
    logic        fault;
    logic [2:0]  state_dbg;

    assign imem_valid = resp_valid | force_valid;

    always #5 clk = ~clk;

    pc_sequencer #(.PC_W(11), .STACK_DEPTH(4), .RESET_PC(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
`ifdef SINGLE_STEP_EN
        .step       (step),
`endif
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_data  (imem_data),
        .ir_opcode  (ir_opcode),
        .ir_field   (ir_field),
        .exec_stb   (exec_stb),
        .mem_op     (mem_op),
        .dp_done    (dp_done),
        .flag_z     (flag_z),
        .flag_n     (flag_n),
        .flag_cy    (flag_cy),
        .fault      (fault),
        .state_dbg  (state_dbg)
    );

    // ------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc = 0;
    int          fetch_cnt = 0;
    int          exec_cnt = 0;
    int          update_cyc = -1;
    int          exec_cyc[$];
    int          imem_delay = 0;
    int          dp_delay = 0;
    int          wait_cnt = 0;
    int          dp_cnt = 0;
    logic [10:0] held_addr = '0;
    logic [15:0] imem [2048];
    logic [10:0] sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s: bound expired", name);
    endtask

    always @(posedge clk) cyc++;

    // Instruction memory: valid after imem_delay waiting cycles, data from imem.
    always @(negedge clk) begin
        if (imem_req) begin
            if (wait_cnt == 0) held_addr = imem_addr;
            else chk("imem_addr_held", {21'b0, imem_addr}, {21'b0, held_addr});
            if (wait_cnt == imem_delay) begin
                resp_valid = 1'b1;
                imem_data  = imem[imem_addr];
                fetch_cnt++;
                if (sb.size() == 0) fail("unexpected_fetch");
                else chk("fetch_addr", {21'b0, imem_addr}, {21'b0, sb.pop_front()});
                wait_cnt = 0;
            end else begin
                resp_valid = 1'b0;
                wait_cnt++;
            end
        end else begin
            resp_valid = 1'b0;
            wait_cnt   = 0;
        end
    end

    // Datapath model: only MOM (8'h14) is a memory op; dp_done arrives
    // dp_delay cycles after the exec_stb cycle.
    always @(negedge clk) begin
        mem_op = (ir_opcode == 8'h14);
        if (exec_stb) begin
            exec_cnt++;
            exec_cyc.push_back(cyc);
            dp_cnt  = 0;
            dp_done = (dp_delay == 0);
        end else if (state_dbg == S_MEMWAIT) begin
            dp_cnt++;
            dp_done = (dp_cnt >= dp_delay);
        end else begin
            dp_done = 1'b0;
        end
        if (state_dbg == S_UPDATE) update_cyc = cyc;
    end

    task automatic do_reset();
        rst_n = 1'b0;
        run = 1'b0; step = 1'b0; force_valid = 1'b0;
        flag_z = 1'b0; flag_n = 1'b0; flag_cy = 1'b0;
        imem_delay = 0; dp_delay = 0;
        for (int i = 0; i < 2048; i++) imem[i] = 16'h0800;
        sb.delete();
        exec_cyc.delete();
        repeat (2) @(negedge clk);
        fetch_cnt = 0; exec_cnt = 0; update_cyc = -1;
        rst_n = 1'b1;
    endtask

    task automatic wait_fetches(input int n, input int budget);
        int b = 0;
        while (fetch_cnt < n && b < budget) begin
            @(negedge clk);
            b++;
        end
        if (fetch_cnt < n) fail("wait_fetches");
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget);
        int b = 0;
        while (state_dbg !== s && b < budget) begin
            @(negedge clk);
            b++;
        end
        if (state_dbg !== s) fail("wait_state");
    endtask

    // ------------------------------------------------------------------
    // Single-instruction vectors: one instruction at pc, expected next PC.
    // ------------------------------------------------------------------
    typedef struct {
        logic [10:0] pc;
        logic [7:0]  op;
        logic [7:0]  fld;
        logic        z, n, cy;
        logic [10:0] nxt;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{11'h000, 8'h23, 8'h45, 1'b0, 1'b0, 1'b0, 11'h345}; // JMP
        vecs[1]  = '{11'h000, 8'h28, 8'h10, 1'b0, 1'b0, 1'b0, 11'h001}; // JZE not taken
        vecs[2]  = '{11'h000, 8'h28, 8'h10, 1'b1, 1'b0, 1'b0, 11'h010}; // JZE taken
        vecs[3]  = '{11'h000, 8'h30, 8'h22, 1'b0, 1'b0, 1'b0, 11'h022}; // JNE taken
        vecs[4]  = '{11'h000, 8'h30, 8'h22, 1'b0, 1'b1, 1'b0, 11'h001}; // JNE not taken
        vecs[5]  = '{11'h000, 8'h38, 8'h77, 1'b0, 1'b0, 1'b1, 11'h077}; // JCY taken
        vecs[6]  = '{11'h000, 8'h38, 8'h77, 1'b0, 1'b0, 1'b0, 11'h001}; // JCY not taken
        vecs[7]  = '{11'h100, 8'h1F, 8'hFE, 1'b0, 1'b0, 1'b0, 11'h0FF}; // BSR -2
        vecs[8]  = '{11'h7FF, 8'h08, 8'h00, 1'b0, 1'b0, 1'b0, 11'h000}; // NOP wraps
        vecs[9]  = '{11'h7FF, 8'h1C, 8'h05, 1'b0, 1'b0, 1'b0, 11'h005}; // BSR wraps
        vecs[10] = '{11'h200, 8'h27, 8'hFF, 1'b0, 1'b0, 1'b0, 11'h7FF}; // JMP max
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        @(negedge clk);
        do_reset();
        rst_n = 1'b0;
        #1;
        // Reset state
        chk("rst_state", {29'b0, state_dbg}, {29'b0, S_IDLE});
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_exec", {31'b0, exec_stb}, 32'd0);
        chk("rst_ir", {16'b0, ir_opcode, ir_field}, 32'd0);
        chk("rst_fault", {31'b0, fault}, 32'd0);
        chk("rst_addr", {21'b0, imem_addr}, 32'd0);

`ifdef SINGLE_STEP_EN
        // Two step pulses, each held high for several instruction times.
        do_reset();
        sb.push_back(11'h000); sb.push_back(11'h001);
        run = 1'b1;
        repeat (10) @(negedge clk);
        chk("step_idle_no_fetch", fetch_cnt, 0);
        for (int k = 0; k < 2; k++) begin
            step = 1'b1;
            repeat (12) @(negedge clk);
            step = 1'b0;
            repeat (4) @(negedge clk);
        end
        chk("step_exec_count", exec_cnt, 2);
        chk("step_state", {29'b0, state_dbg}, {29'b0, S_IDLE});
        chk("step_pc", {21'b0, imem_addr}, 32'h002);
        chk("step_sb_drain", sb.size(), 0);
`else
        // Table-driven single-instruction vectors.
        for (int v = 0; v < 11; v++) begin
            do_reset();
            if (vecs[v].pc != 11'h000) begin
                imem[0] = {5'b00100, vecs[v].pc[10:8], vecs[v].pc[7:0]};
                sb.push_back(11'h000);
            end
            imem[vecs[v].pc] = {vecs[v].op, vecs[v].fld};
            sb.push_back(vecs[v].pc);
            sb.push_back(vecs[v].nxt);
            flag_z = vecs[v].z; flag_n = vecs[v].n; flag_cy = vecs[v].cy;
            n = sb.size();
            run = 1'b1;
            wait_fetches(n, 100);
            run = 1'b0;
            chk($sformatf("vec%0d_drain", v), sb.size(), 0);
        end

        // Straight line: 4 NOPs, exec every 4 cycles, next fetch at 4.
        do_reset();
        for (int a = 0; a <= 4; a++) sb.push_back(11'(a));
        run = 1'b1;
        wait_fetches(5, 100);
        run = 1'b0;
        if (exec_cyc.size() >= 4) begin
            for (int i = 0; i < 3; i++)
                chk($sformatf("nop_period%0d", i), exec_cyc[i+1] - exec_cyc[i], 4);
        end else fail("nop_exec_count");

        // BSR then RET.
        do_reset();
        imem[0] = 16'h2100; imem[11'h100] = 16'h1FFE; imem[11'h0FF] = 16'h4100;
        sb.push_back(11'h000); sb.push_back(11'h100);
        sb.push_back(11'h0FF); sb.push_back(11'h101);
        run = 1'b1;
        wait_fetches(3, 100);
        chk("bsr_stack_top", {21'b0, dut.w_stack_top}, 32'h101);
        wait_fetches(4, 100);
        run = 1'b0;
        chk("ret_stack_empty", {31'b0, dut.w_stack_empty}, 32'd1);
        chk("ret_drain", sb.size(), 0);

        // Five nested BSRs on a 4-deep stack.
        do_reset();
        for (int a = 0; a < 5; a++) begin
            imem[a] = 16'h1C00;
            sb.push_back(11'(a));
        end
        run = 1'b1;
        wait_state(S_HALT, 100);
        repeat (6) @(negedge clk);
        chk("ovf_fault", {31'b0, fault}, 32'd1);
        chk("ovf_state", {29'b0, state_dbg}, {29'b0, S_HALT});
        chk("ovf_req", {31'b0, imem_req}, 32'd0);
        chk("ovf_pc", {21'b0, imem_addr}, 32'h004);
        chk("ovf_exec_count", exec_cnt, 5);
        chk("ovf_fetches", fetch_cnt, 5);

        // RET with empty stack.
        do_reset();
        imem[0] = 16'h4100;
        sb.push_back(11'h000);
        run = 1'b1;
        wait_state(S_HALT, 50);
        repeat (3) @(negedge clk);
        chk("unf_fault", {31'b0, fault}, 32'd1);
        chk("unf_req", {31'b0, imem_req}, 32'd0);
        chk("unf_pc", {21'b0, imem_addr}, 32'h000);

        // MOM with dp_done three cycles after exec, then with dp_done at exec.
        for (int d = 0; d < 4; d += 3) begin
            do_reset();
            dp_delay = d;
            imem[0] = 16'h1400;
            sb.push_back(11'h000); sb.push_back(11'h001);
            run = 1'b1;
            wait_fetches(2, 100);
            run = 1'b0;
            chk($sformatf("mom%0d_exec_count", d), exec_cnt, 1);
            if (exec_cyc.size() > 0)
                chk($sformatf("mom%0d_update_lat", d), update_cyc - exec_cyc[0], d + 1);
            else fail("mom_exec_seen");
        end

        // Slow instruction memory: request and address held while waiting.
        do_reset();
        imem_delay = 5;
        sb.push_back(11'h000); sb.push_back(11'h001);
        run = 1'b1;
        wait_fetches(2, 100);
        run = 1'b0;
        chk("slow_exec_count", exec_cnt, 1);

        // Reset asserted during a fetch; stray valid afterwards is ignored.
        do_reset();
        imem_delay = 20;
        run = 1'b1;
        wait_state(S_FETCH, 20);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rstfetch_req", {31'b0, imem_req}, 32'd0);
        chk("rstfetch_state", {29'b0, state_dbg}, {29'b0, S_IDLE});
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        imem_data = 16'h2345;
        force_valid = 1'b1;
        repeat (3) @(negedge clk);
        force_valid = 1'b0;
        chk("stray_state", {29'b0, state_dbg}, {29'b0, S_IDLE});
        chk("stray_ir", {24'b0, ir_opcode}, 32'h00);

        // run dropped during MEMWAIT: instruction retires, then IDLE.
        do_reset();
        dp_delay = 6;
        imem[0] = 16'h1400;
        sb.push_back(11'h000);
        run = 1'b1;
        wait_state(S_MEMWAIT, 50);
        run = 1'b0;
        wait_state(S_IDLE, 50);
        repeat (5) @(negedge clk);
        chk("runoff_state", {29'b0, state_dbg}, {29'b0, S_IDLE});
        chk("runoff_req", {31'b0, imem_req}, 32'd0);
        chk("runoff_pc", {21'b0, imem_addr}, 32'h001);
        chk("runoff_exec_count", exec_cnt, 1);
        chk("runoff_fetches", fetch_cnt, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_pc_sequencer
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch/execute sequencer for the EV22 core.
- Owns the PC and the BSR/RET return stack.
- Fetches 16-bit instructions over a req/valid handshake from instruction memory, presents opcode/field to the combinational decoder, and issues one exec strobe per instruction to the datapath.
- Resolves JMP/JZE/JNE/JCY/BSR/RET itself from the opcode and the datapath flags.

Parameters:
- PC_W, 11, PC/instruction-address width; JMP target {op[2:0],field[7:0]}.
- STACK_DEPTH, 4, return-stack entries (power of two, 2..16).
- RESET_PC, 0, PC value loaded at reset.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- run  in  1  level; 0 holds the sequencer in IDLE after the current instruction retires
- imem_req  out  1  fetch request, held until imem_valid
- imem_addr  out  PC_W  fetch address (= PC), stable while imem_req
- imem_valid  in  1  instruction data valid (1+ cycles after req)
- imem_data  in  16  {opcode[15:8], field[7:0]}
- ir_opcode  out  8  latched opcode, to decoder OPCODE
- ir_field  out  8  latched field; [7:3]=Ri, [4:0]=Rj path per decoder wiring
- exec_stb  out  1  one-cycle pulse: datapath commits decoded instruction
- mem_op  in  1  decoder MR|MW for the current instruction
- dp_done  in  1  datapath memory access finished (sampled only when mem_op)
- flag_z, flag_n, flag_cy  in  1  W==0, W[15], carry, valid at exec
- fault  out  1  sticky: stack overflow/underflow; cleared only by reset
- state_dbg  out  3  current state encoding

Behaviour:
- Reset (async, rst_n=0): PC=RESET_PC, SP=0, state=IDLE, imem_req=0, exec_stb=0, ir_opcode=8'h00, ir_field=0, fault=0.
- IDLE: if run && !fault -> FETCH.
- FETCH:
  - imem_req=1, imem_addr=PC.
  - On imem_valid: latch ir, -> DECODE.
  - imem_req drops the cycle after valid.
- DECODE: one cycle for decoder outputs to settle; -> EXEC.
- EXEC:
  - exec_stb=1 for exactly one cycle (first EXEC cycle).
  - If mem_op, stay in MEMWAIT until dp_done, else -> UPDATE.
- MEMWAIT: -> UPDATE on dp_done. dp_done in the same cycle as exec_stb is legal and advances immediately.
- UPDATE, next PC:
  - 00100xxx JMP: PC=X.
  - 00101xxx JZE: X if flag_z.
  - 00110xxx JNE: X if !flag_n.
  - 00111xxx JCY: X if flag_cy.
  - 000111ss BSR: push PC+1; PC=PC+1+sext({ss,field}) (10-bit signed).
  - 01000001 RET: PC=pop.
  - Else PC=PC+1.
  - All PC arithmetic is modulo 2^PC_W (wrap).
  - Then -> FETCH if run, else IDLE.
- Flags are sampled in UPDATE (post-exec values, registered by the datapath).
- Stack:
  - Push when SP==STACK_DEPTH: no write, fault=1, PC unchanged, -> HALT.
  - Pop when SP==0: fault=1, -> HALT.
- HALT: terminal until reset; imem_req=0, no exec_stb.
- run deasserted mid-instruction: the current instruction completes through UPDATE, then IDLE. No fetch is abandoned mid-handshake.
- rst_n asserted mid-fetch: req drops immediately; pending imem_valid after reset is ignored (state IDLE).
- Latency without memory op: minimum 4 cycles/instruction with 1-cycle imem.

Optional Feature:
- SINGLE_STEP_EN defined:
  - Extra input step (1 bit).
  - After UPDATE the sequencer enters IDLE regardless of run, and leaves IDLE only on a rising edge of step (edge-detect register, reset 0).
  - run is ignored.
- Undefined: no step port; behaviour as above.

Decomposition:
- Shared package ev22_pkg:
  - state enum (IDLE, FETCH, DECODE, EXEC, MEMWAIT, UPDATE, HALT).
  - Opcode pattern constants (OP_JMP=5'b00100, OP_JZE, OP_JNE, OP_JCY, OP_BSR=6'b000111, OP_RET=8'h41).
  - INSTR_W=16.
- One sub-module: ret_stack (push/pop, data, full/empty, SP), instantiated once.

Test Plan:
- Straight line: imem holds 4 NOPs (8'h08 MOV), 1-cycle valid -> PCs 0,1,2,3 fetched, exec_stb every 4 cycles, PC=4.
- JMP opcode 8'h23 field 8'h45 at PC 0 -> next imem_addr=0x345. JZE 8'h28/8'h10 with flag_z=0 -> PC=1; with flag_z=1 -> 0x010.
- BSR 8'h1F field 8'hFE at PC 0x100 (offset -2) -> PC=0xFF, stack top 0x101. RET at 0xFF -> PC=0x101, SP=0.
- Five nested BSR with STACK_DEPTH=4 -> fault=1 on fifth, state HALT, imem_req stays 0. RET at reset -> fault=1.
- MOM W,Y (8'h14) with dp_done after 3 cycles -> single exec_stb, UPDATE 3 cycles later, PC+1. imem_valid delayed 5 cycles -> imem_req/addr held stable.
- rst_n low during FETCH -> imem_req=0 same cycle. run=0 during MEMWAIT -> instruction retires, IDLE, no new req. SINGLE_STEP_EN: two step pulses -> exactly two exec_stb.
